addr4u_fault_monitor: RTL and testbench

ADDR4U_FAULT_MONITOR -- requirements
Module: addr4u_fault_monitor

---
 rtl/addr4u_fault_monitor.sv | 156 +++++++++++++++
 tb/tb_addr4u_fault_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/addr4u_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module   : addr4u_fault_monitor
// Purpose  : Watches an external 4-bit adder. Each accepted operand/result
//            pair is checked against a locally computed golden sum and
//            forwarded through a single valid/ready output register.
//            Repeated consecutive mismatches latch an ALARM state. In ALARM
//            the golden sum replaces the adder result. Only cnt_clr leaves
//            ALARM.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W   width of the saturating total-mismatch counter (>= 2)
//   THRESH  consecutive mismatches that force ALARM (1..15)
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (deassert synchronously)
//   in_valid   in   operand/result pair presented
//   in_ready   out  monitor accepts the pair this cycle
//   a, b       in   4-bit operands driven to the upstream adder
//   sum_dut    in   5-bit adder result for a, b (same cycle)
//   out_valid  out  registered result available
//   out_ready  in   downstream accepts the result
//   sum_out    out  corrected sum (pass-through in RUN, golden in ALARM)
//   err        out  registered pair was a mismatch
//   alarm      out  state register is ALARM
//   err_cnt    out  total mismatches, saturating
//   cnt_clr    in   synchronous clear of counters and ALARM
// ============================================================================
module addr4u_fault_monitor #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [4:0]       sum_dut,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       sum_out,
  output logic             err,
  output logic             alarm,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             cnt_clr
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    ALARM = 1'b1
  } state_t;

  localparam logic [3:0]       THRESH_C  = 4'(THRESH);
  localparam logic [3:0]       CONSEC_MAX = 4'hF;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       consec;
  logic [3:0]       consec_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;

  logic             accept;
  logic [4:0]       golden;
  logic             mismatch;
  logic             trigger;
  logic             substitute;
  logic [4:0]       sum_sel;

  // Single output register: a new pair can enter whenever the register is
  // empty or is being drained in the same cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Zero-extended add keeps the carry as bit 4.
  assign golden   = {1'b0, a} + {1'b0, b};
  assign mismatch = (sum_dut != golden);

  // --------------------------------------------------------------------------
  // Next-state / counter logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    consec_nxt  = consec;
    err_cnt_nxt = err_cnt;
    trigger     = 1'b0;

    if (accept) begin
      if (mismatch) begin
        if (consec != CONSEC_MAX) begin
          consec_nxt = consec + 4'd1;
        end
        if (err_cnt != CNT_MAX) begin
          err_cnt_nxt = err_cnt + CNT_ONE;
        end
        if ((state == RUN) && (consec_nxt >= THRESH_C)) begin
          trigger   = 1'b1;
          state_nxt = ALARM;
        end
      end else begin
        consec_nxt = 4'd0;
      end
    end

    // Clear has priority over any simultaneous accepted mismatch.
    if (cnt_clr) begin
      state_nxt   = RUN;
      consec_nxt  = 4'd0;
      err_cnt_nxt = '0;
    end

    // The pair that trips the alarm already uses the golden value, unless a
    // simultaneous clear cancelled the trip.
    substitute = (state == ALARM) || (trigger && !cnt_clr);
    sum_sel    = substitute ? golden : sum_dut;
  end

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      consec  <= 4'd0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      consec  <= consec_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

  assign alarm = (state == ALARM);

  // --------------------------------------------------------------------------
  // Output register; cnt_clr has no effect here, so a held result survives it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum_out   <= 5'd0;
      err       <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      sum_out   <= sum_sel;
      err       <= mismatch;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_addr4u_fault_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_addr4u_fault_monitor
// Purpose  : Directed bench for addr4u_fault_monitor (CNT_W=2, THRESH=3).
//            Stimulus pushes hand-computed expected results into a queue.
//            A monitor pops and compares on every output transfer.
// Revision : 1.0  initial release
// ============================================================================
module tb_addr4u_fault_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] sum_dut;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] sum_out;
  logic       err;
  logic       alarm;
  logic [1:0] err_cnt;
  logic       cnt_clr;

  typedef struct {
    logic [4:0] s;
    logic       e;
    logic       al;
    logic [1:0] c;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  addr4u_fault_monitor #(.CNT_W(2), .THRESH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sum_dut   (sum_dut),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .err       (err),
    .alarm     (alarm),
    .err_cnt   (err_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  // Present one pair (with optional cnt_clr) and record the expected result
  // as it will be observed when drained.
  task automatic send(input logic [3:0] ia, input logic [3:0] ib,
                      input logic [4:0] isd, input logic clr,
                      input logic [4:0] es, input logic ee,
                      input logic ea, input logic [1:0] ec,
                      output int waited);
    exp_t t;
    int n = 0;
    in_valid = 1'b1; a = ia; b = ib; sum_dut = isd; cnt_clr = clr;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      t.s = es; t.e = ee; t.al = ea; t.c = ec;
      q.push_back(t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  // Monitor: one comparison set per output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("sum_out", int'(sum_out), int'(mon_e.s));
        chk("err",     int'(err),     int'(mon_e.e));
        chk("alarm",   int'(alarm),   int'(mon_e.al));
        chk("err_cnt", int'(err_cnt), int'(mon_e.c));
      end
    end
  end

  initial begin
    int w;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; a = 4'h0; b = 4'h0; sum_dut = 5'h0;
    out_ready = 1'b1; cnt_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_sum_out",   int'(sum_out),   0);
    chk("rst_alarm",     int'(alarm),     0);
    chk("rst_err_cnt",   int'(err_cnt),   0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Matching pairs, full throughput
    send(4'hF, 4'hF, 5'h1E, 1'b0, 5'h1E, 1'b0, 1'b0, 2'd0, w);
    send(4'h5, 4'h6, 5'h0B, 1'b0, 5'h0B, 1'b0, 1'b0, 2'd0, w);
    send(4'h0, 4'h0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 2'd0, w);
    send(4'h9, 4'h7, 5'h10, 1'b0, 5'h10, 1'b0, 1'b0, 2'd0, w);
    @(posedge clk); #1;

    // Backpressure: hold for two cycles, then drain and accept together
    out_ready = 1'b0;
    send(4'h2, 4'h3, 5'h05, 1'b0, 5'h05, 1'b0, 1'b0, 2'd0, w);
    @(negedge clk);
    chk("bp_in_ready_1", int'(in_ready),  0);
    chk("bp_out_valid",  int'(out_valid), 1);
    chk("bp_sum_hold_1", int'(sum_out),   5);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_in_ready_2", int'(in_ready),  0);
    chk("bp_sum_hold_2", int'(sum_out),   5);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'h1, 4'h1, 5'h02, 1'b0, 5'h02, 1'b0, 1'b0, 2'd0, w);
    chk("bp_same_cycle_accept", w, 0);

    // Three consecutive mismatches trip ALARM; third uses golden
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd1, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd2, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h07, 1'b1, 1'b1, 2'd3, w);
    // ALARM persists through matches, substitutes golden, counter saturates
    send(4'h2, 4'h2, 5'h04, 1'b0, 5'h04, 1'b0, 1'b1, 2'd3, w);
    send(4'h1, 4'h2, 5'h1F, 1'b0, 5'h03, 1'b1, 1'b1, 2'd3, w);
    send(4'h6, 4'h6, 5'h0C, 1'b0, 5'h0C, 1'b0, 1'b1, 2'd3, w);
    @(posedge clk); #1;

    // cnt_clr pulse leaves ALARM
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_alarm",   int'(alarm),   0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    @(posedge clk); #1;

    // cnt_clr with simultaneous mismatch: not counted, captured normally
    send(4'h3, 4'h4, 5'h08, 1'b1, 5'h08, 1'b1, 1'b0, 2'd0, w);
    // Five mismatches: err_cnt saturates at 3
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd1, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd2, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h07, 1'b1, 1'b1, 2'd3, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h07, 1'b1, 1'b1, 2'd3, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h07, 1'b1, 1'b1, 2'd3, w);
    @(posedge clk); #1;

    // cnt_clr while a result is held: output untouched
    out_ready = 1'b0;
    send(4'h4, 4'h4, 5'h08, 1'b0, 5'h08, 1'b0, 1'b0, 2'd0, w);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clrhold_out_valid", int'(out_valid), 1);
    chk("clrhold_sum_out",   int'(sum_out),   8);
    chk("clrhold_err",       int'(err),       0);
    chk("clrhold_alarm",     int'(alarm),     0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd1, w);
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd2, w);
    @(posedge clk); #1;

    // Third mismatch held un-drained in ALARM, then asynchronous reset
    out_ready = 1'b0;
    in_valid = 1'b1; a = 4'h3; b = 4'h4; sum_dut = 5'h08;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", int'(out_valid), 1);
    chk("pre_rst_alarm",     int'(alarm),     1);
    chk("pre_rst_sum_out",   int'(sum_out),   7);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_sum_out",   int'(sum_out),   0);
    chk("arst_err",       int'(err),       0);
    chk("arst_alarm",     int'(alarm),     0);
    chk("arst_err_cnt",   int'(err_cnt),   0);
    chk("arst_in_ready",  int'(in_ready),  1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    send(4'h8, 4'h8, 5'h10, 1'b0, 5'h10, 1'b0, 1'b0, 2'd0, w);
    // Consecutive count must have been cleared by reset: no alarm here
    send(4'h3, 4'h4, 5'h08, 1'b0, 5'h08, 1'b1, 1'b0, 2'd1, w);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
